// File: rtl/reg_file_clr_if.sv
// Bus bundle for reg_file_clr: two combinational read ports, one write port
// with active-low enable, and the clear engine request/status lines.
interface reg_file_clr_if #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 2
);
  logic [ADDR_W-1:0] adr_r_a;
  logic [ADDR_W-1:0] adr_r_b;
  logic [DATA_W-1:0] out_a;
  logic [DATA_W-1:0] out_b;
  logic              w_e_n;
  logic [ADDR_W-1:0] adr_w;
  logic [DATA_W-1:0] data_w;
  logic              clr_req;
  logic              busy;
  logic              clr_done;
  logic              w_drop;

  // Datapath side: issues addresses, write data and clear requests.
  modport master (
    output adr_r_a, adr_r_b, w_e_n, adr_w, data_w, clr_req,
    input  out_a, out_b, busy, clr_done, w_drop
  );

  // Register file side.
  modport slave (
    input  adr_r_a, adr_r_b, w_e_n, adr_w, data_w, clr_req,
    output out_a, out_b, busy, clr_done, w_drop
  );
endinterface

// File: rtl/reg_file_clr.sv
// General-purpose register/data store: DEPTH x DATA_W array with two
// zero-latency read ports, one write port (optional same-cycle forwarding)
// and a clear engine that zeroes one entry per cycle while busy is high.
module reg_file_clr #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 2,
  parameter bit BYPASS = 1'b1
) (
  input  logic           clock,
  input  logic           reset_n,
  reg_file_clr_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_e;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] w_ptr_nxt;
  logic              r_busy;
  logic              w_busy_nxt;
  logic              r_clr_done;
  logic              w_clr_done_nxt;
  logic              r_w_drop;
  logic              w_w_drop_nxt;

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_wr_en;
  logic [ADDR_W-1:0] w_wr_adr;
  logic [DATA_W-1:0] w_wr_data;
  logic              w_last;
  logic              w_fwd_a;
  logic              w_fwd_b;

  // The sweep ends on the edge that clears the top entry.
  assign w_last = (r_ptr == {ADDR_W{1'b1}});

  // Next-state and array write-port selection: the clear engine owns the
  // write port while sweeping, otherwise the external write goes through.
  // NOTE: every signal gets a default first so no path leaves one unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_busy_nxt     = 1'b0;
    w_clr_done_nxt = 1'b0;
    w_w_drop_nxt   = 1'b0;
    w_wr_en        = 1'b0;
    w_wr_adr       = bus.adr_w;
    w_wr_data      = bus.data_w;
    case (r_state)
      S_IDLE: begin
        // A write and a clear request on the same edge both take effect;
        // the sweep later zeroes the freshly written entry.
        w_wr_en = ~bus.w_e_n;
        if (bus.clr_req) begin
          w_state_nxt = S_CLEAR;
          w_ptr_nxt   = '0;
          w_busy_nxt  = 1'b1;
        end
      end
      S_CLEAR: begin
        w_wr_en      = 1'b1;
        w_wr_adr     = r_ptr;
        w_wr_data    = '0;
        w_ptr_nxt    = r_ptr + 1'b1;
        // External writes are discarded and flagged; clr_req is ignored.
        w_w_drop_nxt = ~bus.w_e_n;
        if (w_last) begin
          w_state_nxt    = S_IDLE;
          w_clr_done_nxt = 1'b1;
        end else begin
          w_busy_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Control state and registered status outputs.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_busy     <= 1'b0;
      r_clr_done <= 1'b0;
      r_w_drop   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_busy     <= w_busy_nxt;
      r_clr_done <= w_clr_done_nxt;
      r_w_drop   <= w_w_drop_nxt;
    end
  end

  // Storage array, written by either the datapath or the clear engine.
  // NOTE: the array is reset because the datapath relies on every register
  // reading zero straight out of reset; this keeps it in flops, not a RAM macro.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_mem[w_wr_adr] <= w_wr_data;
    end
  end

  // Forwarding is only legal in IDLE, where the pending write will land.
  assign w_fwd_a = BYPASS && (r_state == S_IDLE) && !bus.w_e_n &&
                   (bus.adr_w == bus.adr_r_a);
  assign w_fwd_b = BYPASS && (r_state == S_IDLE) && !bus.w_e_n &&
                   (bus.adr_w == bus.adr_r_b);

  assign bus.out_a    = w_fwd_a ? bus.data_w : r_mem[bus.adr_r_a];
  assign bus.out_b    = w_fwd_b ? bus.data_w : r_mem[bus.adr_r_b];
  assign bus.busy     = r_busy;
  assign bus.clr_done = r_clr_done;
  assign bus.w_drop   = r_w_drop;

endmodule

// File: tb/tb_reg_file_clr.sv
// Directed bench for reg_file_clr: the stimulus thread queues the value each
// output must show in the current cycle; a monitor samples on the falling
// edge and compares against the queue head.
module tb_reg_file_clr;

  typedef enum int {SIG_A, SIG_B, SIG_BUSY, SIG_DONE, SIG_DROP} sig_e;

  typedef struct {
    int          cyc;
    int          dut;
    sig_e        sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  reg_file_clr_if #(.DATA_W(4), .ADDR_W(2)) n_if ();
  reg_file_clr_if #(.DATA_W(4), .ADDR_W(2)) b_if ();
  reg_file_clr_if #(.DATA_W(8), .ADDR_W(4)) w_if ();

  reg_file_clr #(.DATA_W(4), .ADDR_W(2), .BYPASS(1'b1)) u_dut (
    .clock(clk), .reset_n(rst_n), .bus(n_if));
  reg_file_clr #(.DATA_W(4), .ADDR_W(2), .BYPASS(1'b0)) u_nobyp (
    .clock(clk), .reset_n(rst_n), .bus(b_if));
  reg_file_clr #(.DATA_W(8), .ADDR_W(4), .BYPASS(1'b1)) u_wide (
    .clock(clk), .reset_n(rst_n), .bus(w_if));

  function automatic logic [31:0] get_val(int dut, sig_e s);
    logic [31:0] v;
    v = '0;
    case (dut)
      0: case (s)
           SIG_A:    v = 32'(n_if.out_a);
           SIG_B:    v = 32'(n_if.out_b);
           SIG_BUSY: v = 32'(n_if.busy);
           SIG_DONE: v = 32'(n_if.clr_done);
           default:  v = 32'(n_if.w_drop);
         endcase
      1: case (s)
           SIG_A:    v = 32'(b_if.out_a);
           SIG_B:    v = 32'(b_if.out_b);
           SIG_BUSY: v = 32'(b_if.busy);
           SIG_DONE: v = 32'(b_if.clr_done);
           default:  v = 32'(b_if.w_drop);
         endcase
      default: case (s)
           SIG_A:    v = 32'(w_if.out_a);
           SIG_B:    v = 32'(w_if.out_b);
           SIG_BUSY: v = 32'(w_if.busy);
           SIG_DONE: v = 32'(w_if.clr_done);
           default:  v = 32'(w_if.w_drop);
         endcase
    endcase
    return v;
  endfunction

  // Monitor: consume every expectation due in this cycle.
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e   = sb.pop_front();
        act = get_val(e.dut, e.sig);
        n_checks++;
        if (e.cyc != cyc) begin
          n_fail++;
          $display("FAIL %s: not sampled in cycle %0d (now %0d)", e.name, e.cyc, cyc);
        end else if (act !== e.val) begin
          n_fail++;
          $display("FAIL %s: dut%0d cycle %0d got %0h expected %0h",
                   e.name, e.dut, cyc, act, e.val);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic want(int dut, sig_e s, logic [31:0] v, string name);
    exp_t e;
    e.cyc  = cyc;
    e.dut  = dut;
    e.sig  = s;
    e.val  = v;
    e.name = name;
    sb.push_back(e);
  endtask

  // Narrow stimulus goes to both the bypass and no-bypass instances.
  task automatic drv(logic we_n, logic [1:0] aw, logic [3:0] dw,
                     logic [1:0] ra, logic [1:0] rb, logic clr);
    n_if.w_e_n = we_n; n_if.adr_w = aw; n_if.data_w = dw;
    n_if.adr_r_a = ra; n_if.adr_r_b = rb; n_if.clr_req = clr;
    b_if.w_e_n = we_n; b_if.adr_w = aw; b_if.data_w = dw;
    b_if.adr_r_a = ra; b_if.adr_r_b = rb; b_if.clr_req = clr;
  endtask

  task automatic drv_w(logic we_n, logic [3:0] aw, logic [7:0] dw,
                       logic [3:0] ra, logic [3:0] rb, logic clr);
    w_if.w_e_n = we_n; w_if.adr_w = aw; w_if.data_w = dw;
    w_if.adr_r_a = ra; w_if.adr_r_b = rb; w_if.clr_req = clr;
  endtask

  initial begin
    rst_n = 1'b0;
    drv(1'b1, 2'd0, 4'h0, 2'd0, 2'd0, 1'b0);
    drv_w(1'b1, 4'd0, 8'h00, 4'd0, 4'd0, 1'b0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Dirty an entry, then reset asynchronously mid-cycle.
    step(); drv(1'b0, 2'd0, 4'h3, 2'd1, 2'd1, 1'b0);
    step(); drv(1'b1, 2'd0, 4'h0, 2'd0, 2'd0, 1'b0);
    #2 rst_n = 1'b0;
    step();
    #2 rst_n = 1'b1;
    step(); drv(1'b1, 2'd0, 4'h0, 2'd0, 2'd1, 1'b0);
    want(0, SIG_A, 0, "rst_rd0"); want(0, SIG_B, 0, "rst_rd1");
    want(0, SIG_BUSY, 0, "rst_busy"); want(0, SIG_DONE, 0, "rst_done");
    want(0, SIG_DROP, 0, "rst_drop");
    step(); drv(1'b1, 2'd0, 4'h0, 2'd2, 2'd3, 1'b0);
    want(0, SIG_A, 0, "rst_rd2"); want(0, SIG_B, 0, "rst_rd3");

    // Write/read with and without forwarding.
    step(); drv(1'b0, 2'd1, 4'hA, 2'd0, 2'd0, 1'b0);
    step(); drv(1'b0, 2'd2, 4'h5, 2'd0, 2'd0, 1'b0);
    step(); drv(1'b0, 2'd3, 4'hF, 2'd3, 2'd1, 1'b0);
    want(0, SIG_A, 4'hF, "byp_a"); want(0, SIG_B, 4'hA, "rd_b");
    want(1, SIG_A, 4'h0, "nobyp_old"); want(1, SIG_B, 4'hA, "nobyp_b");
    step(); drv(1'b1, 2'd3, 4'hF, 2'd3, 2'd2, 1'b0);
    want(0, SIG_A, 4'hF, "rd_f"); want(1, SIG_A, 4'hF, "nobyp_new");
    want(0, SIG_B, 4'h5, "rd_5");

    // Clear sweep over 1..4.
    for (int i = 0; i < 4; i++) begin
      step(); drv(1'b0, 2'(i), 4'(i + 1), 2'd0, 2'd0, 1'b0);
    end
    step(); drv(1'b1, 2'd0, 4'h0, 2'd0, 2'd0, 1'b1);
    want(0, SIG_BUSY, 0, "pre_busy");
    for (int k = 1; k <= 4; k++) begin
      step(); drv(1'b1, 2'd0, 4'h0, 2'(k - 1), (k >= 2) ? 2'(k - 2) : 2'd0, 1'b0);
      want(0, SIG_BUSY, 1, "sweep_busy");
      want(0, SIG_DONE, 0, "sweep_done_low");
      want(0, SIG_A, 32'(k), "sweep_keep");
      want(0, SIG_B, (k >= 2) ? 32'd0 : 32'd1, "sweep_zero");
      want(1, SIG_BUSY, 1, "nobyp_busy");
    end
    step(); drv(1'b1, 2'd0, 4'h0, 2'd3, 2'd0, 1'b0);
    want(0, SIG_BUSY, 0, "sweep_busy_fall"); want(0, SIG_DONE, 1, "done_pulse");
    want(0, SIG_A, 0, "sweep_last"); want(0, SIG_B, 0, "sweep_first");
    step(); drv(1'b1, 2'd0, 4'h0, 2'd1, 2'd2, 1'b0);
    want(0, SIG_DONE, 0, "done_once");
    want(0, SIG_A, 0, "sweep_e1"); want(0, SIG_B, 0, "sweep_e2");

    // Writes during a clear are dropped and flagged.
    step(); drv(1'b0, 2'd2, 4'h6, 2'd0, 2'd0, 1'b0);
    step(); drv(1'b1, 2'd0, 4'h0, 2'd0, 2'd0, 1'b1);
    step(); drv(1'b1, 2'd0, 4'h0, 2'd2, 2'd0, 1'b0);
    want(0, SIG_BUSY, 1, "wc_busy1");
    step(); drv(1'b0, 2'd2, 4'h7, 2'd2, 2'd0, 1'b0);
    want(0, SIG_A, 4'h6, "clr_no_byp"); want(0, SIG_DROP, 0, "drop_not_yet");
    step(); drv(1'b0, 2'd0, 4'h7, 2'd2, 2'd0, 1'b0);
    want(0, SIG_DROP, 1, "w_drop"); want(0, SIG_A, 4'h6, "wc_keep2");
    step(); drv(1'b1, 2'd0, 4'h0, 2'd0, 2'd2, 1'b0);
    want(0, SIG_DROP, 1, "w_drop2"); want(0, SIG_A, 0, "drop_disc0");
    want(0, SIG_B, 0, "wc_zero2");
    step(); drv(1'b1, 2'd0, 4'h0, 2'd2, 2'd0, 1'b0);
    want(0, SIG_DROP, 0, "drop_end"); want(0, SIG_DONE, 1, "wc_done");
    want(0, SIG_A, 0, "wc_after");
    step();
    want(0, SIG_DROP, 0, "drop_quiet");

    // Write and clear request on the same IDLE edge.
    step(); drv(1'b0, 2'd3, 4'h9, 2'd3, 2'd0, 1'b1);
    want(0, SIG_A, 4'h9, "sim_byp"); want(0, SIG_BUSY, 0, "sim_idle");
    for (int k = 1; k <= 4; k++) begin
      step(); drv(1'b1, 2'd0, 4'h0, 2'd3, 2'd0, 1'b0);
      want(0, SIG_BUSY, 1, "sim_busy"); want(0, SIG_A, 4'h9, "sim_keep");
    end
    step();
    want(0, SIG_BUSY, 0, "sim_busy_fall"); want(0, SIG_DONE, 1, "sim_done");
    want(0, SIG_A, 0, "sim_zero");

    // clr_req held high: ignored while busy, restarts after one IDLE cycle.
    step(); drv(1'b1, 2'd0, 4'h0, 2'd0, 2'd0, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      step();
      want(0, SIG_BUSY, 1, "held_busy");
    end
    step();
    want(0, SIG_BUSY, 0, "held_gap"); want(0, SIG_DONE, 1, "held_done");
    step(); drv(1'b1, 2'd0, 4'h0, 2'd0, 2'd0, 1'b0);
    want(0, SIG_BUSY, 1, "held_restart"); want(0, SIG_DONE, 0, "held_done_low");
    for (int k = 2; k <= 4; k++) begin
      step();
      want(0, SIG_BUSY, 1, "held_busy2");
    end
    step();
    want(0, SIG_BUSY, 0, "held_end"); want(0, SIG_DONE, 1, "held_done2");

    // Reset in the second busy cycle aborts the clear.
    step(); drv(1'b0, 2'd3, 4'h8, 2'd0, 2'd0, 1'b0);
    step(); drv(1'b1, 2'd0, 4'h0, 2'd3, 2'd0, 1'b1);
    step(); drv(1'b1, 2'd0, 4'h0, 2'd3, 2'd0, 1'b0);
    want(0, SIG_BUSY, 1, "mr_busy1"); want(0, SIG_A, 4'h8, "mr_keep");
    step();
    #2 rst_n = 1'b0;
    want(0, SIG_BUSY, 0, "rst_mid_busy"); want(0, SIG_A, 0, "rst_mid_mem");
    want(0, SIG_DONE, 0, "rst_mid_done");
    step();
    #2 rst_n = 1'b1;
    want(0, SIG_BUSY, 0, "rst_rel_busy"); want(0, SIG_DONE, 0, "rst_rel_done");
    step();
    want(0, SIG_DONE, 0, "rst_no_done"); want(0, SIG_BUSY, 0, "rst_idle");
    step();
    want(0, SIG_DONE, 0, "rst_no_done2");

    // Wide instance: 16-cycle sweeps, second sweep starts from entry 0.
    step(); drv_w(1'b0, 4'd15, 8'hC3, 4'd0, 4'd0, 1'b0);
    step(); drv_w(1'b0, 4'd0, 8'h5A, 4'd0, 4'd0, 1'b0);
    step(); drv_w(1'b1, 4'd0, 8'h00, 4'd15, 4'd0, 1'b1);
    want(2, SIG_A, 8'hC3, "wide_pre"); want(2, SIG_BUSY, 0, "wide_idle");
    for (int k = 1; k <= 16; k++) begin
      step(); drv_w(1'b1, 4'd0, 8'h00, 4'd15, 4'd0, 1'b0);
      want(2, SIG_BUSY, 1, "wide_busy");
      want(2, SIG_A, 8'hC3, "wide_keep");
      want(2, SIG_B, (k == 1) ? 32'h5A : 32'h0, "wide_zero0");
    end
    step();
    want(2, SIG_BUSY, 0, "wide_fall"); want(2, SIG_DONE, 1, "wide_done");
    want(2, SIG_A, 0, "wide_last");
    step(); drv_w(1'b0, 4'd5, 8'h11, 4'd0, 4'd0, 1'b0);
    want(2, SIG_DONE, 0, "wide_done_once");
    step(); drv_w(1'b1, 4'd0, 8'h00, 4'd5, 4'd0, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      step(); drv_w(1'b1, 4'd0, 8'h00, 4'd5, 4'd0, 1'b0);
      want(2, SIG_BUSY, 1, "wide_busy2");
      want(2, SIG_A, (k <= 6) ? 32'h11 : 32'h0, "wide_wrap");
    end
    step();
    want(2, SIG_BUSY, 0, "wide_fall2"); want(2, SIG_DONE, 1, "wide_done2");

    step();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_clr.md
Name: reg_file_clr

Overview:
Parametrised successor of the team's 4x4 two-read/one-write data memory.
- Width and depth are generic.
- Adds optional write-to-read bypass.
- Adds a sequential clear engine that zeroes the array one entry per cycle on request.
- Sits in the miniprocessor datapath as the general-purpose register/data store, next to the instruction memory and ALU.

Parameters:
DATA_W, 4, width of each entry and of data_w/out_a/out_b
ADDR_W, 2, address width; DEPTH = 2**ADDR_W entries
BYPASS, 1, 1 = a same-cycle write forwards to a matching read port; 0 = reads show stored contents only

Ports:
clock  input  1  single clock; all state updates on its rising edge
reset_n  input  1  asynchronous, active-low reset
adr_r_a  input  ADDR_W  read port A address
adr_r_b  input  ADDR_W  read port B address
out_a  output  DATA_W  read port A data (combinational)
out_b  output  DATA_W  read port B data (combinational)
w_e_n  input  1  write enable, active-low
adr_w  input  ADDR_W  write address
data_w  input  DATA_W  write data
clr_req  input  1  start-clear request, sampled on the clock edge, active-high
busy  output  1  high while the clear engine owns the array
clr_done  output  1  one-cycle pulse after the last entry is cleared
w_drop  output  1  one-cycle pulse: a write was rejected because the clear engine was active

Behaviour:
- Reset (reset_n=0, asynchronous): all DEPTH entries = 0, state = IDLE, clear pointer = 0, busy = 0, clr_done = 0, w_drop = 0. out_a/out_b then read 0 for every address.
- Reset released mid-clear: the engine aborts; the array is already zero from reset.
- States:
  - IDLE -> CLEAR when clr_req=1 at a clock edge.
  - CLEAR -> IDLE after the edge that writes entry DEPTH-1.
- Reads:
  - out_x = MEM[adr_r_x], zero-latency combinational. Both ports are independent; both may address the same entry.
  - With BYPASS=1, state=IDLE, w_e_n=0 and adr_w==adr_r_x: out_x = data_w in the same cycle.
  - With BYPASS=0, or in CLEAR: no forwarding; the new value appears the cycle after the write edge.
- Write: in IDLE with w_e_n=0, MEM[adr_w] <= data_w at the edge.
- Clear engine (in CLEAR):
  - Each edge: MEM[ptr] <= 0, ptr <= ptr+1 (ptr is ADDR_W bits; it wraps to 0 after DEPTH-1).
  - busy is a registered output. It is 1 from the edge that samples clr_req through the edge that clears entry DEPTH-1, i.e. exactly DEPTH cycles.
  - clr_done = 1 for the single cycle immediately after busy falls.
  - Reads during CLEAR return the partially cleared contents: entries below ptr are 0, the rest are unchanged.
- Writes during CLEAR (w_e_n=0 while busy=1): discarded, array untouched; w_drop pulses high the following cycle.
- clr_req while busy: ignored; it does not restart or extend the clear.
- clr_req and write on the same IDLE edge: the write is performed at that edge and the clear starts from that edge. The written entry is zeroed later in the sweep, so the result is an all-zero array.
- clr_req held high continuously: a new clear starts on the first edge after returning to IDLE, back-to-back with one IDLE cycle (the cycle with clr_done=1).
- Reads never stall; no handshake on reads or writes beyond busy/w_drop.

Test Plan:
- Reset then read: assert reset_n=0 asynchronously mid-cycle, release. Required: out_a=out_b=0 for all addresses 0..3; busy=0, clr_done=0, w_drop=0.
- Write/read, BYPASS=1, defaults:
  - Write 4'hA@1, 4'h5@2, 4'hF@3 on consecutive cycles, with adr_r_a=3 and adr_r_b=1 during the write of F. Required: out_a=F in that cycle (bypass) and out_b=A.
  - With BYPASS=0, out_a shows old value 0 until the next cycle.
- Clear sweep:
  - Fill 1..4 into 0..3, pulse clr_req one cycle. Required: busy=1 for exactly 4 cycles; entry k reads 0 from the cycle after the k-th clear edge while higher entries keep their values.
  - clr_done pulses once after busy falls; all entries read 0.
- Write during clear: issue w_e_n=0, adr_w=2, data_w=7 in the 2nd busy cycle. Required: w_drop=1 the next cycle; entry 2 reads 0 after clr_done; no further w_drop.
- Simultaneous clr_req and write in IDLE: write 9@3 on the same edge as clr_req. Required: out reads 9 at addr 3 until the 4th clear edge, then 0; busy lasts 4 cycles.
- Mid-clear reset and wide config:
  - Assert reset_n=0 in busy cycle 2. Required: busy=0 immediately, no clr_done.
  - Repeat the sweep with DATA_W=8, ADDR_W=4. Required: busy lasts 16 cycles, and ptr wraps to 0 cleanly for a second clear.
